regfile_read_arbiter: RTL
=========================

// Module: regfile_read_arbiter
// PURPOSE
// - Shares the single register-file read port (address select -> 32:1 read mux) among NUM_REQ requesters.
// - Round-robin arbitration, 2-stage pipeline: arbitrate/drive select, then capture read data.
// - Returns tagged responses with valid/ready backpressure.
// - Sits between the decode/operand-fetch requesters and the regfile read port.
// PARAMETERS
// - NUM_REQ  4   number of requesters (2..8)
// - ADDR_W   5   register select width (32 registers)
// - DATA_W   32  register data width
// - ID_W     2   requester tag width, = clog2(NUM_REQ)
// PORTS
// - clock     in   1               rising-edge clock
// - reset     in   1               asynchronous, active-high reset
// - req       in   NUM_REQ         per-requester read request; held until its gnt bit pulses
// - req_addr  in   NUM_REQ*ADDR_W  packed register indices; requester i at [i*ADDR_W +: ADDR_W]
// - gnt       out  NUM_REQ         one-hot, one-cycle grant pulse (registered)
// - rf_sel    out  ADDR_W          select to regfile read port (registered)
// - rf_data   in   DATA_W          regfile read data for rf_sel (combinational, same cycle)
// - rsp_valid out  1               response valid
// - rsp_ready in   1               response consumer ready
// - rsp_id    out  ID_W            requester index of the response
// - rsp_data  out  DATA_W          read data; register 0 always reads 0
// BEHAVIOUR
// - Reset: gnt=0, rf_sel=0, rsp_valid=0, rsp_id=0, rsp_data=0, s1_valid=0, rr_ptr=0.
// - Stage 1 (ARB), on each edge when not stalled:
//   - Winner = first set req bit searching from rr_ptr upward, wrapping at NUM_REQ-1 -> 0.
//   - With a winner: gnt[winner]=1 for one cycle, rf_sel=req_addr[winner], s1_id=winner,
//     s1_valid=1, rr_ptr=(winner+1) mod NUM_REQ.
//   - Without a winner: gnt=0, s1_valid=0; rf_sel and rr_ptr hold.
// - Stage 2 (RSP), on the edge after stage 1 loads with s1_valid=1 and not stalled:
//   - rsp_data = (rf_sel==0) ? 0 : rf_data; rsp_id = s1_id; rsp_valid=1.
// - Latency: req sampled at edge N -> gnt high in cycle N+1 -> rsp_valid high in cycle N+2.
// - Throughput: one response per cycle while rsp_ready=1.
// - Handshake: a response transfers on the edge where rsp_valid & rsp_ready.
//   rsp_valid drops afterwards unless a new stage-2 load occurs on the same edge.
// - Stall = rsp_valid & ~rsp_ready. While stalled:
//   - Stage 1 and stage 2 hold all contents; no new grants, gnt=0.
//   - rf_sel stays stable so rf_data stays valid.
// - Requester protocol:
//   - A requester deasserts req (or changes req_addr) only in the cycle after its gnt pulse.
//   - req still high after that is a new request, arbitrated normally.
// - Simultaneous events:
//   - All req high: grants rotate 0,1,2,3,0,...
//   - A request arriving during a stall waits; arbitration resumes on the edge the stall clears.
// - Reset mid-operation: in-flight stage-1/stage-2 entries are discarded; no response is issued for them.
// CONFIGURATION
// - Macro RF_ARB_WR_BYPASS_EN. When defined:
//   - Adds ports wr_en (in 1), wr_addr (in ADDR_W), wr_data (in DATA_W).
//   - If wr_en & (wr_addr==rf_sel) & (rf_sel!=0) in the stage-2 capture cycle, rsp_data = wr_data
//     (write-to-read forwarding of the same-cycle regfile write).
// - When undefined: ports absent; rsp_data always comes from rf_data (regfile write-then-read
//   ordering is the requester's concern).
// STRUCTURE
// - Shared include regfile_defs.vh:
//   - `RF_ADDR_W (5), `RF_DATA_W (32), `RF_NUM_REGS (32), `RF_ZERO_REG (5'd0).
//   - Stage-valid/id field widths used by all regfile-port controllers.
// - Sub-module rr_priority_pick:
//   - Combinational; inputs req and rr_ptr; outputs one-hot winner, winner index, and any.
//   - Reused by the planned write-port arbiter.
// - Top-level: stage-1 registers (gnt, rf_sel, s1_id, s1_valid, rr_ptr), stage-2 registers
//   (rsp_*), stall logic.
// TESTING
// - Reset release, req=0 for 10 cycles -> gnt=0, rsp_valid=0, rf_sel=0 throughout.
// - Single request: req=4'b0100, addr2=5'd7, regfile r7=32'hDEADBEEF ->
//   gnt=4'b0100 at N+1, rsp_valid/rsp_id=2/rsp_data=32'hDEADBEEF at N+2.
// - req=4'b1111 held, rsp_ready=1 -> gnt sequence 0001,0010,0100,1000,0001;
//   rsp_id sequence 0,1,2,3,0 back to back.
// - Backpressure: rsp_ready=0 for 3 cycles with rsp_valid=1 ->
//   rsp_data/rsp_id/rf_sel stable, gnt=0; resumes the cycle after rsp_ready=1, nothing lost or duplicated.
// - req addr=5'd0 while regfile r0 holds nonzero garbage -> rsp_data=32'h0.
// - Mid-pipeline reset pulse with s1_valid=1 -> all outputs at reset values, no stale response;
//   with RF_ARB_WR_BYPASS_EN, wr_en=1, wr_addr=rf_sel=5'd9, wr_data=32'h1234 -> rsp_data=32'h1234.

Source files
------------

// File: rtl/regfile_read_arbiter_pkg.sv
// Shared regfile-port constants and helpers for the regfile read/write port controllers.
// Build option: RF_ARB_WR_BYPASS_EN (consumed by the interface and top, not here).
package regfile_read_arbiter_pkg;

  // Regfile geometry
  localparam int unsigned RF_ADDR_W   = 5;
  localparam int unsigned RF_DATA_W   = 32;
  localparam int unsigned RF_NUM_REGS = 32;
  localparam logic [RF_ADDR_W-1:0] RF_ZERO_REG = 5'd0;

  // Read-port requester configuration
  localparam int unsigned RF_NUM_REQ = 4;
  localparam int unsigned RF_ID_W    = 2;

  // Next round-robin pointer: one past the winner, wrapping at n-1 -> 0.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/regfile_read_arbiter_if.sv
// Requester / regfile / response bundle for the regfile read-port arbiter.
//   req, req_addr        requester side: request bits and packed register indices
//   gnt                  one-hot grant pulse back to requesters
//   rf_sel, rf_data      regfile read port (select out, same-cycle data in)
//   rsp_*                tagged response with valid/ready handshake
//   wr_en/wr_addr/wr_data  same-cycle regfile write, only with RF_ARB_WR_BYPASS_EN
// Modports: slave = arbiter, master = surrounding pipeline / regfile.
interface regfile_read_arbiter_if
  import regfile_read_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = RF_NUM_REQ,
  parameter int unsigned ADDR_W  = RF_ADDR_W,
  parameter int unsigned DATA_W  = RF_DATA_W,
  parameter int unsigned ID_W    = RF_ID_W
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]         rf_sel;
  logic [DATA_W-1:0]         rf_data;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;

`ifdef RF_ARB_WR_BYPASS_EN
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;

  modport master (
    output req, req_addr, rf_data, rsp_ready, wr_en, wr_addr, wr_data,
    input  gnt, rf_sel, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req, req_addr, rf_data, rsp_ready, wr_en, wr_addr, wr_data,
    output gnt, rf_sel, rsp_valid, rsp_id, rsp_data
  );
`else
  modport master (
    output req, req_addr, rf_data, rsp_ready,
    input  gnt, rf_sel, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req, req_addr, rf_data, rsp_ready,
    output gnt, rf_sel, rsp_valid, rsp_id, rsp_data
  );
`endif

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set req bit at or above rr_ptr, wrapping.
//   req          request vector
//   rr_ptr       highest-priority position this cycle
//   win_onehot_c one-hot winner (zero when nothing requested)
//   win_idx_c    winner index (zero when nothing requested)
//   any_c        at least one request present
module rr_priority_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     win_onehot_c,
  output logic [IDX_W-1:0] win_idx_c,
  output logic             any_c
);

  logic [N-1:0]     rot_c;
  logic [IDX_W-1:0] off_c;
  logic [IDX_W:0]   sum_c;

  // Rotate so bit 0 is the requester at rr_ptr; doubled vector makes the wrap free.
  assign rot_c = N'({req, req} >> rr_ptr);

  // Lowest set bit of the rotated vector, then map the offset back to a requester index.
  always_comb begin
    off_c = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (rot_c[k]) off_c = IDX_W'(k);
    end
    sum_c = {1'b0, rr_ptr} + {1'b0, off_c};
    if (sum_c >= (IDX_W+1)'(N)) sum_c = sum_c - (IDX_W+1)'(N);
    any_c        = |req;
    win_idx_c    = any_c ? IDX_W'(sum_c) : '0;
    win_onehot_c = any_c ? (N'(1) << win_idx_c) : '0;
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares the single regfile read port among NUM_REQ requesters.
// Two stages: ARB (round-robin pick, drive rf_sel, pulse gnt) and RSP (capture rf_data,
// present tagged response under valid/ready). Register 0 always reads as zero.
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   bus           regfile_read_arbiter_if.slave (req/gnt, rf_sel/rf_data, rsp_*)
// Build option: RF_ARB_WR_BYPASS_EN adds wr_en/wr_addr/wr_data and forwards a same-cycle
// regfile write to the captured response.
module regfile_read_arbiter
  import regfile_read_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = RF_NUM_REQ,
  parameter int unsigned ADDR_W  = RF_ADDR_W,
  parameter int unsigned DATA_W  = RF_DATA_W,
  parameter int unsigned ID_W    = RF_ID_W
) (
  input  logic                   clock,
  input  logic                   reset,
  regfile_read_arbiter_if.slave  bus
);

  // Stage-1 (ARB) registers
  logic [NUM_REQ-1:0] gnt_q;
  logic [ADDR_W-1:0]  sel_q;
  logic [ID_W-1:0]    s1_id_q;
  logic               s1_valid_q;
  logic [ID_W-1:0]    ptr_q;

  // Stage-2 (RSP) registers
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [DATA_W-1:0]  rsp_data_q;

  logic               stall_c;
  logic [NUM_REQ-1:0] win_onehot_c;
  logic [ID_W-1:0]    win_idx_c;
  logic               win_any_c;
  logic [ADDR_W-1:0]  win_addr_c;
  logic [DATA_W-1:0]  cap_data_c;

  // Response held but not taken: freeze both stages so rf_sel (and thus rf_data) stays put.
  assign stall_c = rsp_valid_q & ~bus.rsp_ready;

  rr_priority_pick #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .req          (bus.req),
    .rr_ptr       (ptr_q),
    .win_onehot_c (win_onehot_c),
    .win_idx_c    (win_idx_c),
    .any_c        (win_any_c)
  );

  // Register index of the winning requester.
  always_comb begin
    win_addr_c = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (win_onehot_c[i]) win_addr_c = bus.req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Data captured into stage 2: zero register wins over everything, then write forwarding.
  always_comb begin
    cap_data_c = bus.rf_data;
`ifdef RF_ARB_WR_BYPASS_EN
    if (bus.wr_en && (bus.wr_addr == sel_q)) cap_data_c = bus.wr_data;
`endif
    if (sel_q == ADDR_W'(RF_ZERO_REG)) cap_data_c = '0;
  end

  // Pipeline registers; reset drops any in-flight entries.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt_q       <= '0;
      sel_q       <= '0;
      s1_id_q     <= '0;
      s1_valid_q  <= 1'b0;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else if (stall_c) begin
      gnt_q <= '0;
    end else begin
      rsp_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        rsp_id_q   <= s1_id_q;
        rsp_data_q <= cap_data_c;
      end
      gnt_q      <= win_onehot_c;
      s1_valid_q <= win_any_c;
      if (win_any_c) begin
        sel_q   <= win_addr_c;
        s1_id_q <= win_idx_c;
        ptr_q   <= ID_W'(rr_next(32'(win_idx_c), NUM_REQ));
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rf_sel    = sel_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule
